// File: rtl/deemphasis_pkg.sv
// Shared constants, coefficients, dequantizer and FSM state type for the
// audio back-end stages (de-emphasis, gain, FIR).
package deemphasis_pkg;

  localparam int QUANT_BITS = 10;
  localparam int TAPS       = 2;
  localparam int COEF_W     = 32;
  localparam int DEQ_W      = 64;

  // Descending ranges: element 0 is the rightmost literal, so YC[0] = -666
  // weights the most recent output held in the y history.
  localparam logic signed [COEF_W-1:0] XC [TAPS-1:0] = '{32'sd179, 32'sd179};
  localparam logic signed [COEF_W-1:0] YC [TAPS-1:0] = '{32'sd0, -32'sd666};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Divide by 2**QUANT_BITS, rounding toward zero.
  function automatic logic signed [DEQ_W-1:0] deq(input logic signed [DEQ_W-1:0] v);
    if (v < 0) deq = -((-v) >>> QUANT_BITS);
    else       deq = v >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/deemphasis.sv
// FM de-emphasis IIR: pops a sample, accumulates TAPS feed-forward and
// feedback products one tap per cycle, then pushes the result downstream.
module deemphasis
  import deemphasis_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int TAPS      = deemphasis_pkg::TAPS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] in,
  output logic                        in_rd_en,
  input  logic                        in_empty,
  output logic signed [DATA_SIZE-1:0] deemph_out,
  output logic                        out_wr_en,
  input  logic                        out_full
);

  localparam int PW = 2 * DATA_SIZE;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t state, next_state;

  logic signed [DATA_SIZE-1:0] x_hist [TAPS];
  logic signed [DATA_SIZE-1:0] y_hist [TAPS];
  logic signed [DATA_SIZE-1:0] acc;
  logic        [TW-1:0]        tap;

  logic signed [PW-1:0]        prod_x, prod_y;
  logic signed [DATA_SIZE-1:0] term;
  logic                        tap_last;

  always_comb begin
    prod_x   = PW'(XC[tap]) * PW'(x_hist[tap]);
    prod_y   = PW'(YC[tap]) * PW'(y_hist[tap]);
    term     = DATA_SIZE'(deq(DEQ_W'(prod_x))) + DATA_SIZE'(deq(DEQ_W'(prod_y)));
    tap_last = (tap == TW'(TAPS - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      tap   <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
      end
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (!in_empty) begin
            x_hist[0] <= in;
            for (int unsigned i = 1; i < TAPS; i++) x_hist[i] <= x_hist[i-1];
            acc <= '0;
            tap <= '0;
          end
        end
        MAC: begin
          acc <= acc + term;
          tap <= tap + TW'(1);
        end
        WRITE: begin
          if (!out_full) begin
            y_hist[0] <= acc;
            for (int unsigned i = 1; i < TAPS; i++) y_hist[i] <= y_hist[i-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    deemph_out = '0;
    case (state)
      IDLE: begin
        if (!in_empty) begin
          in_rd_en   = 1'b1;
          next_state = MAC;
        end
      end
      MAC: begin
        if (tap_last) next_state = WRITE;
      end
      WRITE: begin
        if (!out_full) begin
          out_wr_en  = 1'b1;
          deemph_out = acc;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        in_rd_en   = 1'bx;
        out_wr_en  = 1'bx;
        deemph_out = 'x;
      end
    endcase
    // Strobes stay quiet for the whole reset pulse, not only after the edge.
    if (!reset) begin
      in_rd_en   = 1'b0;
      out_wr_en  = 1'b0;
      deemph_out = '0;
    end
  end

endmodule
